// File: rtl/ahb_resp_mux.sv
// AHB return-path multiplexer: routes the data-phase slave's hrdata/hready/hresp back to the
// master, with a wait-state watchdog that forces a two-cycle ERROR when a slave stalls too long.
module ahb_resp_mux #(
    parameter int DW      = 32,
    parameter int TIMEOUT = 16
) (
    input  logic          hclk,
    input  logic          hresetn,
    input  logic [1:0]    sel,
    input  logic [1:0]    htrans,
    input  logic [DW-1:0] hrdata_1,
    input  logic [DW-1:0] hrdata_2,
    input  logic [DW-1:0] hrdata_3,
    input  logic [DW-1:0] hrdata_4,
    input  logic          hreadyout_1,
    input  logic          hreadyout_2,
    input  logic          hreadyout_3,
    input  logic          hreadyout_4,
    input  logic          hresp_1,
    input  logic          hresp_2,
    input  logic          hresp_3,
    input  logic          hresp_4,
    output logic [DW-1:0] hrdata,
    output logic          hready,
    output logic          hresp,
    output logic          timeout_pulse
);

    localparam bit          WD_EN    = (TIMEOUT != 0);
    localparam logic [15:0] CNT_LAST = (TIMEOUT > 0) ? 16'(TIMEOUT - 1) : 16'd0;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_DATA = 2'd1,
        ST_ERR1 = 2'd2,
        ST_ERR2 = 2'd3
    } state_e;

    state_e        r_state;
    state_e        w_state_nxt;
    logic [1:0]    r_dsel;
    logic [15:0]   r_cnt;

    logic [DW-1:0] w_slv_rdata;
    logic          w_slv_ready;
    logic          w_slv_resp;
    logic          w_accept;
    logic          w_real_xfer;
    logic          w_wd_fire;
    logic          w_unused;

    // SEQ vs NONSEQ does not matter for response routing.
    assign w_unused    = htrans[0];
    assign w_real_xfer = htrans[1];
    // Our own hready marks the end of a data phase, i.e. the edge that accepts an address phase.
    assign w_accept    = hready;
    assign w_wd_fire   = WD_EN && (r_cnt == CNT_LAST);

    // NOTE: every output of an always_comb gets a default first so no path can infer a latch.
    always_comb begin
        w_slv_rdata = hrdata_1;
        w_slv_ready = hreadyout_1;
        w_slv_resp  = hresp_1;
        case (r_dsel)
            2'd1: begin
                w_slv_rdata = hrdata_2;
                w_slv_ready = hreadyout_2;
                w_slv_resp  = hresp_2;
            end
            2'd2: begin
                w_slv_rdata = hrdata_3;
                w_slv_ready = hreadyout_3;
                w_slv_resp  = hresp_3;
            end
            2'd3: begin
                w_slv_rdata = hrdata_4;
                w_slv_ready = hreadyout_4;
                w_slv_resp  = hresp_4;
            end
            default: ;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge hclk or negedge hresetn) begin
        if (!hresetn) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        if (w_accept) begin
            w_state_nxt = w_real_xfer ? ST_DATA : ST_IDLE;
        end else begin
            case (r_state)
                ST_DATA: if (w_wd_fire) w_state_nxt = ST_ERR1;
                ST_ERR1: w_state_nxt = ST_ERR2;
                default: ;
            endcase
        end
    end

    always_comb begin
        hrdata        = '0;
        hready        = 1'b1;
        hresp         = 1'b0;
        timeout_pulse = 1'b0;
        case (r_state)
            ST_DATA: begin
                hrdata = w_slv_rdata;
                hready = w_slv_ready;
                hresp  = w_slv_resp;
            end
            ST_ERR1: begin
                hready        = 1'b0;
                hresp         = 1'b1;
                timeout_pulse = 1'b1;
            end
            ST_ERR2: begin
                hresp = 1'b1;
            end
            default: ;
        endcase
    end

    // Data-phase select and wait counter; the counter saturates rather than wrapping.
    always_ff @(posedge hclk or negedge hresetn) begin
        if (!hresetn) begin
            r_dsel <= 2'd0;
            r_cnt  <= 16'd0;
        end else if (w_accept) begin
            if (w_real_xfer) begin
                r_dsel <= sel;
                r_cnt  <= 16'd0;
            end
        end else if (r_state == ST_DATA && r_cnt != 16'hFFFF) begin
            r_cnt <= r_cnt + 16'd1;
        end
    end

endmodule

// File: tb/tb_ahb_resp_mux.sv
// Randomized bench for ahb_resp_mux: transfers are planned as (slave, wait count, error, data)
// and the expected per-cycle return-path outputs are derived from each transfer's plan.
module tb_ahb_resp_mux;

    localparam int TO = 4;

    typedef struct {
        int          sel;
        int          waits;
        bit          err;
        int          gap;
        logic [31:0] data;
        bit          rst_err1;
    } xfer_t;

    logic        hclk;
    logic        hresetn;
    logic [1:0]  sel;
    logic [1:0]  htrans;
    logic [31:0] rd  [4];
    logic        rdy [4];
    logic        rsp [4];
    logic [31:0] hrdata;
    logic        hready;
    logic        hresp;
    logic        timeout_pulse;

    int          n_checks;
    int          n_errors;
    xfer_t       plan[$];

    ahb_resp_mux #(.DW(32), .TIMEOUT(TO)) dut (
        .hclk          (hclk),
        .hresetn       (hresetn),
        .sel           (sel),
        .htrans        (htrans),
        .hrdata_1      (rd[0]),
        .hrdata_2      (rd[1]),
        .hrdata_3      (rd[2]),
        .hrdata_4      (rd[3]),
        .hreadyout_1   (rdy[0]),
        .hreadyout_2   (rdy[1]),
        .hreadyout_3   (rdy[2]),
        .hreadyout_4   (rdy[3]),
        .hresp_1       (rsp[0]),
        .hresp_2       (rsp[1]),
        .hresp_3       (rsp[2]),
        .hresp_4       (rsp[3]),
        .hrdata        (hrdata),
        .hready        (hready),
        .hresp         (hresp),
        .timeout_pulse (timeout_pulse)
    );

    initial hclk = 1'b0;
    always #5 hclk = ~hclk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] pack_out();
        return {29'd0, hready, hresp, timeout_pulse, hrdata};
    endfunction

    function automatic logic [63:0] pack_exp(input bit r, input bit e, input bit p, input logic [31:0] d);
        return {29'd0, r, e, p, d};
    endfunction

    task automatic add_xfer(input int s, input int w, input bit e, input int g,
                            input logic [31:0] d, input bit re);
        xfer_t x;
        x.sel = s; x.waits = w; x.err = e; x.gap = g; x.data = d; x.rst_err1 = re;
        plan.push_back(x);
    endtask

    // Runs the planned transfers one cycle at a time; entered and left at posedge + 1.
    task automatic run_plan();
        xfer_t       cur;
        xfer_t       nxt;
        bit          cur_v;
        bit          nxt_v;
        bit          wd;
        bit          exp_rdy;
        bit          exp_rsp;
        bit          exp_pulse;
        logic [31:0] exp_data;
        int          k;
        int          guard;
        cur   = '{sel: 0, waits: 0, err: 1'b0, gap: 0, data: 32'd0, rst_err1: 1'b0};
        nxt   = cur;
        cur_v = 1'b0;
        k     = 0;
        guard = 0;
        while ((plan.size() != 0 || cur_v) && guard < 20000) begin
            guard++;
            for (int s = 0; s < 4; s++) begin
                rd[s]  = $urandom;
                rdy[s] = 1'($urandom_range(0, 1));
                rsp[s] = 1'($urandom_range(0, 1));
            end
            exp_rdy = 1'b1; exp_rsp = 1'b0; exp_pulse = 1'b0; exp_data = 32'd0; wd = 1'b0;
            if (cur_v) begin
                wd = (cur.waits >= TO);
                if (wd && k == TO) begin
                    exp_rdy = 1'b0; exp_rsp = 1'b1; exp_pulse = 1'b1;
                end else if (wd && k == TO + 1) begin
                    exp_rsp = 1'b1;
                end else begin
                    rd[cur.sel]  = cur.data;
                    rdy[cur.sel] = (k >= cur.waits);
                    rsp[cur.sel] = cur.err && (k >= cur.waits - 1);
                    exp_rdy  = rdy[cur.sel];
                    exp_rsp  = rsp[cur.sel];
                    exp_data = cur.data;
                end
            end
            nxt_v = 1'b0;
            if (exp_rdy) begin
                htrans = 2'($urandom_range(0, 1));
                sel    = 2'($urandom);
                if (plan.size() != 0) begin
                    nxt = plan[0];
                    if (nxt.gap > 0) begin
                        nxt.gap = nxt.gap - 1;
                        plan[0] = nxt;
                    end else begin
                        void'(plan.pop_front());
                        nxt_v  = 1'b1;
                        htrans = 2'(2 + $urandom_range(0, 1));
                        sel    = 2'(nxt.sel);
                    end
                end
            end else begin
                htrans = 2'($urandom);
                sel    = 2'($urandom);
            end
            #1;
            check($sformatf("sel%0d_w%0d_k%0d", cur.sel, cur.waits, k), pack_out(),
                  pack_exp(exp_rdy, exp_rsp, exp_pulse, exp_data));
            if (cur_v && wd && k == TO && cur.rst_err1) begin
                hresetn = 1'b0;
                #1;
                check("rst_in_err1", pack_out(), pack_exp(1'b1, 1'b0, 1'b0, 32'd0));
                @(posedge hclk);
                #1;
                check("rst_held", pack_out(), pack_exp(1'b1, 1'b0, 1'b0, 32'd0));
                hresetn = 1'b1;
                cur_v   = 1'b0;
                k       = 0;
                continue;
            end
            @(posedge hclk);
            #1;
            if (exp_rdy) begin
                cur_v = nxt_v;
                cur   = nxt;
                k     = 0;
            end else begin
                k++;
            end
        end
        check("plan_drained", 64'(plan.size() + int'(cur_v)), 64'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "global time limit reached");
    end

    initial begin
        int w;
        n_checks = 0;
        n_errors = 0;
        hresetn  = 1'b0;
        htrans   = 2'b10;
        sel      = 2'd2;
        for (int s = 0; s < 4; s++) begin
            rd[s] = $urandom; rdy[s] = 1'b0; rsp[s] = 1'b1;
        end
        #1;
        check("reset_async", pack_out(), pack_exp(1'b1, 1'b0, 1'b0, 32'd0));
        repeat (2) @(posedge hclk);
        #1;
        check("reset_held", pack_out(), pack_exp(1'b1, 1'b0, 1'b0, 32'd0));
        hresetn = 1'b1;

        // Idle after reset, then pipelined zero-wait pair (slave 3 then slave 1).
        add_xfer(2, 0, 1'b0, 3, 32'hA5A5A5A5, 1'b0);
        add_xfer(0, 0, 1'b0, 0, 32'h12345678, 1'b0);
        // Three wait states on slave 2.
        add_xfer(1, 3, 1'b0, 0, 32'hCAFE0002, 1'b0);
        // Two-cycle slave ERROR from slave 4.
        add_xfer(3, 1, 1'b1, 0, 32'hDEAD0004, 1'b0);
        // Slave 3 stuck low: watchdog abort, then idle.
        add_xfer(2, 100, 1'b0, 0, 32'h0BAD0003, 1'b0);
        // Ready on the last allowed wait cycle: normal completion.
        add_xfer(2, TO - 1, 1'b0, 2, 32'h600D0003, 1'b0);
        // Reset pulse while in ERR1.
        add_xfer(1, 100, 1'b0, 0, 32'h0BAD0002, 1'b1);
        add_xfer(0, 0, 1'b0, 1, 32'h11110001, 1'b0);
        run_plan();

        for (int i = 0; i < 250; i++) begin
            w = $urandom_range(0, TO + 1);
            add_xfer($urandom_range(0, 3), w,
                     (w >= 1 && w < TO) ? ($urandom_range(0, 3) == 0) : 1'b0,
                     ($urandom_range(0, 3) == 0) ? $urandom_range(1, 2) : 0,
                     $urandom,
                     (w >= TO) ? ($urandom_range(0, 7) == 0) : 1'b0);
        end
        run_plan();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
